// File: rtl/nios_cpu_gpio_ext.sv
// Avalon-MM GPIO: WIDTH-bit bidirectional port with per-bit direction, atomic
// set/clear, synchronised inputs, configurable edge capture and maskable irq.
module nios_cpu_gpio_ext #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_OUT   = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_CAP    = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    logic [WIDTH-1:0]                  r_out;
    logic [WIDTH-1:0]                  r_dir;
    logic [WIDTH-1:0]                  r_mask;
    logic [WIDTH-1:0]                  r_cap;
    logic [WIDTH-1:0]                  r_prev;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [SYNC_STAGES:0]              r_prime;
    logic [31:0]                       r_rdata;
    logic                              r_irq;

    logic             w_wr;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_w1c;
    logic [WIDTH-1:0] w_data_rd;
    logic [31:0]      w_rd;
    logic             w_unused_wd;

    assign w_wr        = chipselect & ~write_n;
    assign w_rd_en     = chipselect & read & write_n;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;
    assign w_s         = r_sync[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge_raw = w_s & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge_raw = ~w_s & r_prev;
        end else begin : g_any
            assign w_edge_raw = w_s ^ r_prev;
        end
    endgenerate

    // After reset the synchroniser refills from zero; edges stay masked until
    // both the last stage and the previous flop hold real pin samples.
    assign w_edge    = r_prime[SYNC_STAGES] ? w_edge_raw : '0;
    assign w_w1c     = (w_wr && address == A_CAP) ? w_wd : '0;
    assign w_data_rd = (r_dir & r_out) | (~r_dir & w_s);

    always_comb begin
        w_rd = 32'h0;
        case (address)
            A_DATA:  w_rd = 32'(w_data_rd);
            A_DIR:   w_rd = 32'(r_dir);
            A_MASK:  w_rd = 32'(r_mask);
            A_CAP:   w_rd = 32'(r_cap);
            default: w_rd = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out   <= RESET_OUT[WIDTH-1:0];
            r_dir   <= RESET_DIR[WIDTH-1:0];
            r_mask  <= '0;
            r_cap   <= '0;
            r_prev  <= '0;
            r_sync  <= '0;
            r_prime <= '0;
            r_rdata <= 32'h0;
            r_irq   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_prev  <= w_s;
            r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
            // Set wins over a same-cycle write-1-clear.
            r_cap   <= (r_cap & ~w_w1c) | w_edge;
            r_irq   <= |(r_cap & r_mask);
            if (w_wr) begin
                case (address)
                    A_DATA:   r_out  <= w_wd;
                    A_DIR:    r_dir  <= w_wd;
                    A_MASK:   r_mask <= w_wd;
                    A_OUTSET: r_out  <= r_out | w_wd;
                    A_OUTCLR: r_out  <= r_out & ~w_wd;
                    default:  ;
                endcase
            end else if (w_rd_en) begin
                r_rdata <= w_rd;
            end
        end
    end

    assign readdata = r_rdata;
    assign out_port = r_out;
    assign oe_port  = r_dir;
    assign irq      = r_irq;

endmodule
